// File: rtl/aes_block_loader_pkg.sv
// Shared definitions for the AES block loader: FSM encoding, block geometry
// and the default RUN timeout.
package aes_block_loader_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        RUN  = 2'd1,
        GAP  = 2'd2
    } state_e;

    localparam int          WORDS_PER_BLOCK = 4;
    localparam int          TIMEOUT_CYC_DEF = 64;
    localparam logic [1:0]  LAST_WORD       = 2'(WORDS_PER_BLOCK - 1);

    // Word slot after i, wrapping from the last word of a block back to 0.
    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == LAST_WORD) ? 2'd0 : i + 2'd1;
    endfunction

endpackage

// File: rtl/aes_block_loader_if.sv
// Upstream word stream plus the AES_top control/data bundle of the loader.
interface aes_block_loader_if;

    logic [31:0]  s_word;
    logic         s_is_key;
    logic         s_valid;
    logic         s_ready;
    logic         AES_data_out_valid;
    logic         AES_en;
    logic [127:0] AES_data_in;
    logic [127:0] AES_key_in;
    logic         busy;
    logic         timeout_err;

    modport master (
        output s_word, s_is_key, s_valid, AES_data_out_valid,
        input  s_ready, AES_en, AES_data_in, AES_key_in, busy, timeout_err
    );

    modport slave (
        input  s_word, s_is_key, s_valid, AES_data_out_valid,
        output s_ready, AES_en, AES_data_in, AES_key_in, busy, timeout_err
    );

endinterface

// File: rtl/aes_block_loader_packer.sv
// 4x32 word packer: word n of a block lands in slot n, MSW first, with its
// own wrapping word counter exposed so the caller can track block progress.
module aes_word_packer
    import aes_block_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         we_i,
    input  logic [31:0]  word_i,
    output logic [127:0] blk_o,
    output logic [1:0]   idx_o
);

    logic [127:0] blk_q;
    logic [1:0]   idx_q;

    // Slot write and word counter advance on every accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            blk_q <= 128'd0;
            idx_q <= 2'd0;
        end else if (we_i) begin
            case (idx_q)
                2'd0:    blk_q[127:96] <= word_i;
                2'd1:    blk_q[95:64]  <= word_i;
                2'd2:    blk_q[63:32]  <= word_i;
                2'd3:    blk_q[31:0]   <= word_i;
                default: blk_q         <= blk_q;
            endcase
            idx_q <= next_idx(idx_q);
        end
    end

    assign blk_o = blk_q;
    assign idx_o = idx_q;

endmodule

// File: rtl/aes_block_loader.sv
// Collects key and plaintext words into 128-bit blocks, then runs AES_top
// one block at a time with a bounded wait for its completion flag.
module aes_block_loader
    import aes_block_loader_pkg::*;
#(
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
)
(
    input  logic               AES_clk,
    input  logic               AES_rst,
    aes_block_loader_if.slave  bus
);

    localparam logic [6:0] RUN_LAST = 7'(TIMEOUT_CYC - 1);

    state_e       state_q, state_d;
    logic         key_valid_q, key_valid_d;
    logic         data_full_q, data_full_d;
    logic         en_q, en_d;
    logic [6:0]   cnt_q, cnt_d;
    logic         timeout_s;
    logic         accept_s, key_we_s, data_we_s;
    logic [1:0]   key_idx_s, data_idx_s;
    logic [127:0] key_blk_s, data_blk_s;

    assign accept_s  = bus.s_valid && (state_q == LOAD);
    assign key_we_s  = accept_s && bus.s_is_key;
    assign data_we_s = accept_s && !bus.s_is_key;

    aes_word_packer u_key_packer (
        .clk    (AES_clk),
        .rst    (AES_rst),
        .we_i   (key_we_s),
        .word_i (bus.s_word),
        .blk_o  (key_blk_s),
        .idx_o  (key_idx_s)
    );

    aes_word_packer u_data_packer (
        .clk    (AES_clk),
        .rst    (AES_rst),
        .we_i   (data_we_s),
        .word_i (bus.s_word),
        .blk_o  (data_blk_s),
        .idx_o  (data_idx_s)
    );

    // Next state, block flags, RUN cycle counter and timeout decode.
    always_comb begin
        state_d     = state_q;
        key_valid_d = key_valid_q;
        data_full_d = data_full_q;
        cnt_d       = cnt_q;
        timeout_s   = 1'b0;

        // Starting a key over invalidates it until its last word arrives.
        if (key_we_s) begin
            if (key_idx_s == 2'd0) begin
                key_valid_d = 1'b0;
            end else if (key_idx_s == LAST_WORD) begin
                key_valid_d = 1'b1;
            end else begin
                key_valid_d = key_valid_q;
            end
        end else begin
            key_valid_d = key_valid_q;
        end

        if (data_we_s && (data_idx_s == LAST_WORD)) begin
            data_full_d = 1'b1;
        end else begin
            data_full_d = data_full_q;
        end

        case (state_q)
            LOAD: begin
                cnt_d = 7'd0;
                if (key_valid_q && data_full_q) begin
                    state_d     = RUN;
                    data_full_d = 1'b0;
                end else begin
                    state_d = LOAD;
                end
            end
            RUN: begin
                cnt_d = cnt_q + 7'd1;
                if (bus.AES_data_out_valid) begin
                    state_d = GAP;
                end else if (cnt_q == RUN_LAST) begin
                    state_d   = GAP;
                    timeout_s = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            GAP: begin
                cnt_d   = 7'd0;
                state_d = LOAD;
            end
            default: begin
                cnt_d   = 7'd0;
                state_d = LOAD;
            end
        endcase

        en_d = (state_d == RUN);
    end

    // State, flag, counter and enable registers.
    always_ff @(posedge AES_clk or posedge AES_rst) begin
        if (AES_rst) begin
            state_q     <= LOAD;
            key_valid_q <= 1'b0;
            data_full_q <= 1'b0;
            cnt_q       <= 7'd0;
            en_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_valid_q <= key_valid_d;
            data_full_q <= data_full_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
        end
    end

    // timeout_err must mark the timing-out RUN cycle itself, so it is decoded.
    assign bus.timeout_err = timeout_s;
    assign bus.AES_en      = en_q;
    assign bus.s_ready     = (state_q == LOAD);
    assign bus.busy        = (state_q == RUN) || (state_q == GAP);
    assign bus.AES_data_in = data_blk_s;
    assign bus.AES_key_in  = key_blk_s;

endmodule

// File: tb/tb_aes_block_loader.sv
// Randomized scoreboard bench for aes_block_loader with a behavioural AES core.
module tb_aes_block_loader;

    localparam int TO = 64;

    typedef struct {
        logic [127:0] key;
        logic [127:0] data;
        int           run_len;
        bit           to;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    aes_block_loader_if bus();

    aes_block_loader #(.TIMEOUT_CYC(TO)) dut (
        .AES_clk (clk),
        .AES_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int           vectors = 0;
    int           errors  = 0;
    exp_t         exp_q[$];
    logic [127:0] mdl_key = 128'd0;
    int           cur_lat = 1000;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural AES core: completes lat cycles into RUN, noise elsewhere.
    int ck = 0;
    bit prev_en = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rst) begin
            ck = 0; prev_en = 1'b0; bus.AES_data_out_valid = 1'b0;
        end else if (bus.AES_en) begin
            ck = prev_en ? ck + 1 : 0;
            prev_en = 1'b1;
            bus.AES_data_out_valid = (ck == cur_lat);
        end else begin
            prev_en = 1'b0;
            bus.AES_data_out_valid = 1'($urandom_range(0, 1));
        end
    end

    // Monitor: pops on every RUN entry and checks the whole RUN/GAP episode.
    bit   in_run = 1'b0;
    bit   post   = 1'b0;
    int   mk = 0, te_cnt = 0, te_k = -1;
    exp_t cur;
    always @(negedge clk) begin
        if (rst) begin
            in_run = 1'b0; post = 1'b0;
        end else if (bus.AES_en) begin
            if (!in_run) begin
                in_run = 1'b1; mk = 0; te_cnt = 0; te_k = -1;
                vectors++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty: RUN entered with %0d expected blocks", exp_q.size());
                    cur = '{key: 128'd0, data: 128'd0, run_len: 0, to: 1'b0};
                end else begin
                    cur = exp_q.pop_front();
                end
            end else begin
                mk++;
            end
            chk("run_key", bus.AES_key_in, cur.key);
            chk("run_data", bus.AES_data_in, cur.data);
            chk("run_ready", bus.s_ready, 1'b0);
            chk("run_busy", bus.busy, 1'b1);
            if (bus.timeout_err) begin te_cnt++; te_k = mk; end
        end else if (in_run) begin
            chk("run_len", mk + 1, cur.run_len);
            chk("te_count", te_cnt, cur.to ? 1 : 0);
            chk("te_cycle", te_k, cur.to ? TO - 1 : -1);
            chk("gap_busy", bus.busy, 1'b1);
            chk("gap_ready", bus.s_ready, 1'b0);
            in_run = 1'b0; post = 1'b1;
        end else if (post) begin
            chk("load_ready", bus.s_ready, 1'b1);
            chk("load_busy", bus.busy, 1'b0);
            post = 1'b0;
        end else begin
            chk("idle_te", bus.timeout_err, 1'b0);
        end
    end

    task automatic push_exp(input logic [127:0] d, input int lat);
        exp_t e;
        e.key = mdl_key; e.data = d;
        e.run_len = (lat < TO) ? lat + 1 : TO;
        e.to = (lat >= TO);
        exp_q.push_back(e);
        cur_lat = lat;
    endtask

    task automatic send_word(input logic [31:0] w, input logic k);
        int g = 0;
        @(negedge clk);
        bus.s_word = w; bus.s_is_key = k; bus.s_valid = 1'b1;
        while (!bus.s_ready && g < 300) begin @(negedge clk); g++; end
        if (g >= 300) begin
            vectors++; errors++;
            $display("FAIL ready_wait: s_ready stayed 0 for %0d cycles", g);
        end
        @(posedge clk);
        #1 bus.s_valid = 1'b0;
    endtask

    task automatic send_blk(input logic [127:0] v, input logic k);
        for (int i = 0; i < 4; i++) send_word(v[127 - 32*i -: 32], k);
    endtask

    // Last word accepted: one more LOAD cycle, then AES_en; junk is refused in RUN.
    task automatic start_check();
        @(negedge clk);
        chk("en_early", bus.AES_en, 1'b0);
        @(negedge clk);
        chk("en_rise", bus.AES_en, 1'b1);
        bus.s_word = $urandom; bus.s_is_key = 1'($urandom_range(0, 1)); bus.s_valid = 1'b1;
        repeat (4) @(negedge clk);
        bus.s_valid = 1'b0;
    endtask

    task automatic idle_check(input int n);
        repeat (n) begin
            @(negedge clk);
            chk("no_start_busy", bus.busy, 1'b0);
            chk("no_start_en", bus.AES_en, 1'b0);
        end
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while ((bus.busy || bus.AES_en) && g < 300) begin @(negedge clk); g++; end
        if (g >= 300) begin
            vectors++; errors++;
            $display("FAIL idle_wait: still busy after %0d cycles", g);
        end
    endtask

    task automatic run_block(input logic [127:0] k, input bit new_key,
                             input logic [127:0] d, input int lat);
        if (new_key) mdl_key = k;
        push_exp(d, lat);
        if (new_key) send_blk(k, 1'b1);
        send_blk(d, 1'b0);
        start_check();
        wait_idle();
    endtask

    task automatic reset_outputs(input string tag);
        chk({tag, "_en"}, bus.AES_en, 1'b0);
        chk({tag, "_data"}, bus.AES_data_in, 128'd0);
        chk({tag, "_key"}, bus.AES_key_in, 128'd0);
        chk({tag, "_busy"}, bus.busy, 1'b0);
        chk({tag, "_te"}, bus.timeout_err, 1'b0);
        chk({tag, "_ready"}, bus.s_ready, 1'b1);
    endtask

    logic [127:0] k2, d2;
    initial begin
        bus.s_word = 32'd0; bus.s_is_key = 1'b0; bus.s_valid = 1'b0;
        bus.AES_data_out_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_outputs("rst");
        @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        reset_outputs("post_rst");

        run_block(128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, 1'b1,
                  128'h000000db_00000000_00000000_00000000, 50);
        run_block(128'd0, 1'b0, 128'ha6f2daeb_140fa720_529e75d5_21cbc681, TO - 1);
        run_block(128'd0, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 1000);
        for (int i = 0; i < 6; i++)
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(0, 1)),
                      {$urandom, $urandom, $urandom, $urandom}, $urandom_range(8, 70));

        // Restarted key: a full data block alone must not start RUN.
        k2 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        mdl_key = k2;
        push_exp(d2, 20);
        send_word(k2[127:96], 1'b1);
        send_word(k2[95:64], 1'b1);
        send_blk(d2, 1'b0);
        idle_check(8);
        send_word(k2[63:32], 1'b1);
        send_word(k2[31:0], 1'b1);
        start_check();
        wait_idle();

        // Reset at RUN cycle 10 clears everything, including the key.
        d2 = {$urandom, $urandom, $urandom, $urandom};
        push_exp(d2, 1000);
        send_blk(d2, 1'b0);
        start_check();
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1 reset_outputs("mid_rst");
        @(posedge clk);
        #3 rst = 1'b0;
        mdl_key = 128'd0;
        @(negedge clk);
        reset_outputs("rel_rst");

        k2 = {$urandom, $urandom, $urandom, $urandom};
        d2 = {$urandom, $urandom, $urandom, $urandom};
        mdl_key = k2;
        push_exp(d2, 30);
        send_blk(d2, 1'b0);
        idle_check(8);
        send_blk(k2, 1'b1);
        start_check();
        wait_idle();

        repeat (3) @(negedge clk);
        chk("sb_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
AES_BLOCK_LOADER -- requirements
Module: aes_block_loader

Interface
REQ-001 Parameter TIMEOUT_CYC, default 64, SHALL set the maximum RUN cycles spent waiting for the core result.
REQ-002 AES_clk  input  1  SHALL be the single clock; all flops update on its rising edge.
REQ-003 AES_rst  input  1  SHALL be the asynchronous, active-high reset.
REQ-004 s_word  input  32  SHALL carry one upstream word.
REQ-005 s_is_key  input  1  SHALL steer the word: 1 writes the key, 0 writes the data.
REQ-006 s_valid  input  1  SHALL flag s_word as valid.
REQ-007 s_ready  output  1  SHALL flag that the loader can accept a word.
REQ-008 AES_data_out_valid  input  1  SHALL be the completion flag from AES_top.
REQ-009 AES_en  output  1  SHALL be the start/hold enable to AES_top.
REQ-010 AES_data_in  output  128  SHALL be the plaintext block to AES_top.
REQ-011 AES_key_in  output  128  SHALL be the cipher key to AES_top.
REQ-012 busy  output  1  SHALL be high in RUN and GAP.
REQ-013 timeout_err  output  1  SHALL pulse for one cycle on a RUN timeout.

Function
REQ-014 The FSM SHALL have three states, LOAD, RUN and GAP; reset enters LOAD.
REQ-015 A word SHALL be accepted only when s_valid and s_ready are both 1; s_ready SHALL equal (state==LOAD).
REQ-016 Word order SHALL be MSW first: words 0..3 fill [127:96], [95:64], [63:32], [31:0].
REQ-017 The key and data paths SHALL each have an independent 2-bit word counter that wraps 3->0 on acceptance.
REQ-018 Accepting key word 0 SHALL clear key_valid; accepting key word 3 SHALL set key_valid.
REQ-019 data_full SHALL set on acceptance of data word 3 and clear on LOAD->RUN.
REQ-020 LOAD->RUN SHALL occur the cycle after data_full & key_valid are both true, including when key word 3 and data word 3 complete in the same sequence.
REQ-021 AES_en SHALL be registered and equal 1 exactly while in RUN.
REQ-022 AES_data_in and AES_key_in SHALL be written only in LOAD and held stable throughout RUN and GAP.
REQ-023 The key SHALL persist across blocks; a new block SHALL need only 4 data words.
REQ-024 In RUN, a 7-bit cycle counter SHALL start at 0 on entry and increment each cycle.
REQ-025 RUN->GAP SHALL occur when AES_data_out_valid==1 is sampled.
REQ-026 RUN->GAP SHALL also occur when the counter reaches TIMEOUT_CYC-1 without valid, with timeout_err=1 for that cycle.
REQ-027 If valid and timeout coincide, valid SHALL win and timeout_err SHALL stay 0.
REQ-028 GAP SHALL last exactly one cycle, with AES_en=0, then return to LOAD.
REQ-029 AES_data_out_valid SHALL be ignored in LOAD and GAP.
REQ-030 Data words in excess of one block SHALL not be accepted, because s_ready=0 outside LOAD.

Reset
REQ-031 Asserting AES_rst SHALL immediately force: state=LOAD, AES_en=0, s_ready=1 after release, busy=0, timeout_err=0, AES_data_in=0, AES_key_in=0, both counters=0, key_valid=0, data_full=0.
REQ-032 Reset mid-RUN SHALL drop AES_en combinationally with the reset flop clear, with no GAP cycle, and SHALL discard the partial key.

Structure
REQ-033 The state encoding (LOAD=2'd0, RUN=2'd1, GAP=2'd2), WORDS_PER_BLOCK=4 and the TIMEOUT_CYC default SHALL live in the shared AES package.
REQ-034 The 4x32 shift-in register SHALL be one sub-module, aes_word_packer, instanced twice (key and data).

Verification
REQ-035 Key aa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc, then data 000000db_00000000_00000000_00000000 -> AES_en rises 1 cycle after the last word, and both buses match the loaded values.
REQ-036 Core model raising valid 50 cycles after AES_en -> AES_en falls the next cycle, 1 GAP cycle follows, then s_ready=1.
REQ-037 Second block a6f2daeb_140fa720_529e75d5_21cbc681 with no new key -> RUN entered with the key unchanged.
REQ-038 Valid never raised, TIMEOUT_CYC=64 -> timeout_err pulses once at RUN cycle 63, then GAP, then LOAD.
REQ-039 AES_rst asserted at RUN cycle 10 -> AES_en=0 and all outputs zero within the same cycle, key_valid=0, and a fresh key is needed before the next RUN.
REQ-040 Key words 0..1 written, then key word 0 rewritten -> key_valid stays 0 and data_full alone does not start RUN.
